// File: rtl/regfile_mp.sv
// Purpose : parametrised 2-read / 1-write decode-stage register file with a sequential clear engine.
// Latency : reads are registered, one edge from address to data; writes land on the same edge.
// Backpressure: none; while the clear engine runs, writes are dropped (out_wr_drop) and reads return 0.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   in_ctrl_regwrt/in_rd/in_rdval   write port (from writeback)
//   in_rs/in_rt                  read addresses; out_rsval/out_rtval registered read data
//   in_clr                       pulse to zero every entry, one entry per cycle
//   out_busy                     high while the clear engine runs
//   out_wr_drop                  one-cycle pulse when a write request was discarded
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_ctrl_regwrt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_rdval,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_clr,
    output logic [DATA_W-1:0] out_rsval,
    output logic [DATA_W-1:0] out_rtval,
    output logic              out_busy,
    output logic              out_wr_drop
);

    localparam int D = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(D - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [D];

    logic              wr_acc;
    logic [DATA_W-1:0] rs_nxt;
    logic [DATA_W-1:0] rt_nxt;

    // A write is architecturally accepted unless it targets the hardwired zero
    // register. Whether the FSM lets it through is decided in the sequential block.
    always_comb begin
        wr_acc = in_ctrl_regwrt;
        if ((ZERO_REG != 0) && (in_rd == '0)) begin
            wr_acc = 1'b0;
        end
    end

    // Per-port read selection: zero register, then same-edge forwarding, then array.
    always_comb begin
        rs_nxt = mem[in_rs];
        if ((ZERO_REG != 0) && (in_rs == '0)) begin
            rs_nxt = '0;
        end else if ((BYPASS != 0) && wr_acc && (in_rd == in_rs)) begin
            rs_nxt = in_rdval;
        end

        rt_nxt = mem[in_rt];
        if ((ZERO_REG != 0) && (in_rt == '0)) begin
            rt_nxt = '0;
        end else if ((BYPASS != 0) && wr_acc && (in_rd == in_rt)) begin
            rt_nxt = in_rdval;
        end
    end

    // Array contents are deliberately left out of the reset branch: the clear
    // engine zeroes them one entry per edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            cnt         <= '0;
            out_busy    <= 1'b1;
            out_rsval   <= '0;
            out_rtval   <= '0;
            out_wr_drop <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[cnt]    <= '0;
                    out_rsval   <= '0;
                    out_rtval   <= '0;
                    out_wr_drop <= in_ctrl_regwrt;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        out_busy <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    if (in_clr) begin
                        // Clear wins over a same-edge write; reads see the array
                        // without forwarding since that write never lands.
                        state       <= CLEAR;
                        cnt         <= '0;
                        out_busy    <= 1'b1;
                        out_wr_drop <= in_ctrl_regwrt;
                        out_rsval   <= mem[in_rs];
                        out_rtval   <= mem[in_rt];
                    end else begin
                        out_wr_drop <= 1'b0;
                        out_rsval   <= rs_nxt;
                        out_rtval   <= rt_nxt;
                        if (wr_acc) begin
                            mem[in_rd] <= in_rdval;
                        end
                    end
                end
            endcase
        end
    end

endmodule
